// File: rtl/uart_tx_core_if.sv
// Parallel word handshake into the UART transmit engine.
// The source drives tx_data/tx_valid; the engine answers with tx_ready.
interface uart_tx_core_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_core.sv
// UART serial transmit engine: one-word holding buffer feeding a framing shifter.
// Frame = start, data_size data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_core #(
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_core_if.slave   bus,
  input  logic [3:0]      data_size,
  input  logic [13:0]     bit_period,
  output logic            tx_out,
  output logic            tx_busy,
  output logic            frame_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam bit PAR_EN  = (PARITY_EN != 0);
  localparam bit PAR_ODD = (PARITY_ODD != 0);

  logic [2:0]  state;
  logic [7:0]  hold;
  logic        buf_full;
  logic [7:0]  shifter;
  logic [3:0]  size_r;
  logic [13:0] period_r;
  logic [13:0] cnt;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        par_bit;

  logic        bit_end;
  logic        last_stop;
  logic        load;
  logic        line_bit;
  logic [3:0]  size_c;
  logic [13:0] period_c;
  logic [7:0]  mask;

  assign bus.tx_ready = !buf_full && !rst;

  always_comb begin
    size_c = data_size;
    if (data_size < 4'd5)
      size_c = 4'd5;
    else if (data_size > 4'd8)
      size_c = 4'd8;
    period_c = (bit_period < 14'd2) ? 14'd2 : bit_period;
    mask = '0;
    for (int unsigned i = 0; i < 8; i++)
      mask[i] = (i < {28'd0, size_c});
  end

  assign bit_end   = (cnt == period_r);
  assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;
  // Loading at the final stop clock lets the next START begin with no idle gap.
  assign load      = buf_full && ((state == IDLE) ||
                                  ((state == STOP) && bit_end && last_stop));

  always_comb begin
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shifter[0];
      PARITY:  line_bit = par_bit;
      default: line_bit = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      buf_full   <= 1'b0;
      shifter    <= '0;
      size_r     <= 4'd8;
      period_r   <= 14'd2;
      cnt        <= 14'd1;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      par_bit    <= 1'b0;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_out     <= line_bit;
      tx_busy    <= (state != IDLE);
      frame_done <= (state == STOP) && bit_end && last_stop;

      if (bus.tx_valid && bus.tx_ready) begin
        hold     <= bus.tx_data;
        buf_full <= 1'b1;
      end

      if (load) begin
        shifter  <= hold;
        size_r   <= size_c;
        period_r <= period_c;
        par_bit  <= (^(hold & mask)) ^ PAR_ODD;
        cnt      <= 14'd1;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        buf_full <= 1'b0;
        state    <= START;
      end else if (state != IDLE) begin
        if (!bit_end) begin
          cnt <= cnt + 14'd1;
        end else begin
          cnt <= 14'd1;
          case (state)
            START: state <= DATA;
            DATA: begin
              shifter <= {1'b0, shifter[7:1]};
              if ({1'b0, bit_idx} == size_r - 4'd1)
                state <= PAR_EN ? PARITY : STOP;
              else
                bit_idx <= bit_idx + 3'd1;
            end
            PARITY: state <= STOP;
            STOP: begin
              if (last_stop)
                state <= IDLE;
              else
                stop_idx <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
